seg7_mux_driver: RTL and testbench

- Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.
- Contains its own refresh counter, hex decode, per-digit dot and enable, anti-ghost guard blanking and 16-level PWM brightness.
- Display content is double-buffered and commits only at frame boundaries, so the display never tears.
- Sits between system logic (counters, CPU registers) and the board display pins. Replaces hand-rolled digit-select logic plus a separate decoder.

---
 rtl/seg7_mux_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed driver for a common-anode seven-segment display.
// It handles digit scanning, hex decode, guard blanking, PWM brightness and tear-free content updates.
module seg7_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                    CLK100_IN,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dot_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT,
    output logic                    frame_done
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;

    // Staging (written by load) and active (shown) content
    logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   stg_dot_q, stg_dot_d, act_dot_q, act_dot_d;
    logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d, act_en_q, act_en_d;
    logic [3:0]              stg_bright_q, stg_bright_d, act_bright_q, act_bright_d;
    logic                    pending_q, pending_d;

    // Registered pin outputs
    logic [NUM_DIGITS-1:0] seg_select_q, seg_select_d;
    logic [7:0]            hex_q, hex_d;
    logic                  frame_done_q, frame_done_d;

    logic       dwell_wrap;
    logic       boundary;
    logic       guard_done;
    logic       lit;
    logic [3:0] cur_nibble;
    logic [6:0] seg_pattern;

    assign dwell_wrap = (dwell_cnt_q == DWELL_LAST);
    assign boundary   = dwell_wrap && (digit_idx_q == IDX_LAST);

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard_done = 1'b1;
        end else begin : g_guard
            assign guard_done = (dwell_cnt_q >= CNT_W'(GUARD_CYCLES));
        end
    endgenerate

    always_comb begin
        dwell_cnt_d = dwell_wrap ? '0 : dwell_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (dwell_wrap) begin
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
        end
        pwm_cnt_d = pwm_cnt_q + 4'd1;
    end

    // A load landing on the boundary bypasses staging so it shows in the very next frame.
    always_comb begin
        stg_data_d   = stg_data_q;
        stg_dot_d    = stg_dot_q;
        stg_en_d     = stg_en_q;
        stg_bright_d = stg_bright_q;
        act_data_d   = act_data_q;
        act_dot_d    = act_dot_q;
        act_en_d     = act_en_q;
        act_bright_d = act_bright_q;
        pending_d    = boundary ? 1'b0 : (pending_q | load);
        if (load) begin
            stg_data_d   = digit_data;
            stg_dot_d    = dot_in;
            stg_en_d     = digit_en;
            stg_bright_d = brightness;
        end
        if (boundary && load) begin
            act_data_d   = digit_data;
            act_dot_d    = dot_in;
            act_en_d     = digit_en;
            act_bright_d = brightness;
        end else if (boundary && pending_q) begin
            act_data_d   = stg_data_q;
            act_dot_d    = stg_dot_q;
            act_en_d     = stg_en_q;
            act_bright_d = stg_bright_q;
        end
    end

    assign cur_nibble = act_data_q[{digit_idx_q, 2'b00} +: 4];
    assign lit = guard_done && act_en_q[digit_idx_q] && (pwm_cnt_q <= act_bright_q);

    always_comb begin
        case (cur_nibble)
            4'h0: seg_pattern = 7'h40;
            4'h1: seg_pattern = 7'h79;
            4'h2: seg_pattern = 7'h24;
            4'h3: seg_pattern = 7'h30;
            4'h4: seg_pattern = 7'h19;
            4'h5: seg_pattern = 7'h12;
            4'h6: seg_pattern = 7'h02;
            4'h7: seg_pattern = 7'h78;
            4'h8: seg_pattern = 7'h00;
            4'h9: seg_pattern = 7'h10;
            4'hA: seg_pattern = 7'h08;
            4'hB: seg_pattern = 7'h03;
            4'hC: seg_pattern = 7'h46;
            4'hD: seg_pattern = 7'h21;
            4'hE: seg_pattern = 7'h06;
            default: seg_pattern = 7'h0E;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign seg_select_d[gi] = ~(lit && (digit_idx_q == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        hex_d        = lit ? {~act_dot_q[digit_idx_q], seg_pattern} : 8'hFF;
        frame_done_d = boundary;
    end

    always_ff @(posedge CLK100_IN or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt_q  <= '0;
            digit_idx_q  <= '0;
            pwm_cnt_q    <= '0;
            stg_data_q   <= '0;
            stg_dot_q    <= '0;
            stg_en_q     <= '0;
            stg_bright_q <= '0;
            act_data_q   <= '0;
            act_dot_q    <= '0;
            act_en_q     <= '0;
            act_bright_q <= '0;
            pending_q    <= 1'b0;
            seg_select_q <= '1;
            hex_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            dwell_cnt_q  <= dwell_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            stg_data_q   <= stg_data_d;
            stg_dot_q    <= stg_dot_d;
            stg_en_q     <= stg_en_d;
            stg_bright_q <= stg_bright_d;
            act_data_q   <= act_data_d;
            act_dot_q    <= act_dot_d;
            act_en_q     <= act_en_d;
            act_bright_q <= act_bright_d;
            pending_q    <= pending_d;
            seg_select_q <= seg_select_d;
            hex_q        <= hex_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SEG_SELECT_OUT = seg_select_q;
    assign HEX_OUT        = hex_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with 4 digits, an 8-cycle dwell and a 2-cycle guard.
// Expected outputs come from the cycle count since reset release plus the content the bench expects to be active.
`timescale 1ns/1ps
module tb_seg7_mux_driver;

    logic        CLK100_IN = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] digit_data;
    logic [3:0]  dot_in;
    logic [3:0]  digit_en;
    logic [3:0]  brightness;
    logic        load;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] exp_data;
    logic [3:0]  exp_dot;
    logic [3:0]  exp_en;
    logic [3:0]  exp_br;
    logic [7:0]  dec_tab [16];

    seg7_mux_driver #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(8),
        .GUARD_CYCLES(2)
    ) dut (
        .CLK100_IN     (CLK100_IN),
        .rst_n         (rst_n),
        .digit_data    (digit_data),
        .dot_in        (dot_in),
        .digit_en      (digit_en),
        .brightness    (brightness),
        .load          (load),
        .SEG_SELECT_OUT(SEG_SELECT_OUT),
        .HEX_OUT       (HEX_OUT),
        .frame_done    (frame_done)
    );

    always #5 CLK100_IN = ~CLK100_IN;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Outputs seen after posedge number cyc reflect the scan state of cycle cyc-1.
    task automatic check_outputs(input string tag);
        int s, cnt, idx, pwm;
        logic lit;
        logic [3:0] nib, eseg;
        logic [7:0] ehex, dtab;
        s    = cyc - 1;
        cnt  = s % 8;
        idx  = (s / 8) % 4;
        pwm  = s % 16;
        lit  = (cnt >= 2) && exp_en[idx] && (pwm <= int'(exp_br));
        nib  = exp_data[idx*4 +: 4];
        dtab = dec_tab[nib];
        eseg = lit ? ~(4'b0001 << idx) : 4'hF;
        ehex = lit ? {~exp_dot[idx], dtab[6:0]} : 8'hFF;
        check8({tag, "_seg"}, {4'h0, SEG_SELECT_OUT}, {4'h0, eseg});
        check8({tag, "_hex"}, HEX_OUT, ehex);
        check8({tag, "_fd"}, {7'h0, frame_done}, {7'h0, (s % 32) == 31});
        $display("cyc=%0d %s seg=%h hex=%h fd=%0b", cyc, tag, SEG_SELECT_OUT, HEX_OUT, frame_done);
    endtask

    task automatic step_chk(input string tag);
        @(posedge CLK100_IN);
        cyc++;
        @(negedge CLK100_IN);
        check_outputs(tag);
    endtask

    task automatic run_until(input int target, input string tag);
        while (cyc < target) step_chk(tag);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] en,
                           input logic [3:0] br, input string tag);
        digit_data = d;
        dot_in     = dt;
        digit_en   = en;
        brightness = br;
        load       = 1'b1;
        step_chk(tag);
        load       = 1'b0;
    endtask

    task automatic set_exp(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] en,
                           input logic [3:0] br);
        exp_data = d;
        exp_dot  = dt;
        exp_en   = en;
        exp_br   = br;
    endtask

    task automatic check_blank_reset(input string tag);
        check8({tag, "_seg"}, {4'h0, SEG_SELECT_OUT}, 8'h0F);
        check8({tag, "_hex"}, HEX_OUT, 8'hFF);
        check8({tag, "_fd"}, {7'h0, frame_done}, 8'h00);
        $display("%s seg=%h hex=%h fd=%0b", tag, SEG_SELECT_OUT, HEX_OUT, frame_done);
    endtask

    initial begin
        dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        digit_data = '0;
        dot_in     = '0;
        digit_en   = '0;
        brightness = '0;
        load       = 1'b0;
        set_exp(16'h0000, 4'h0, 4'h0, 4'h0);

        // 1: reset state, then idle scanning with a blank display
        repeat (3) @(negedge CLK100_IN);
        check_blank_reset("reset");
        rst_n = 1'b1;
        cyc   = 0;
        run_until(40, "idle");

        // 2: content shows only after the next boundary
        do_load(16'hCA80, 4'b1010, 4'hF, 4'hF, "loadA");
        run_until(64, "holdA");
        set_exp(16'hCA80, 4'b1010, 4'hF, 4'hF);
        run_until(97, "showA");

        // 3: two loads in one frame, only the second is committed
        run_until(100, "showA");
        do_load(16'h1234, 4'b0000, 4'hF, 4'hF, "loadB");
        run_until(110, "showA");
        do_load(16'h5678, 4'b0101, 4'b1011, 4'hF, "loadC");
        run_until(128, "showA");
        set_exp(16'h5678, 4'b0101, 4'b1011, 4'hF);
        run_until(159, "showC");

        // 4: load on the boundary cycle itself
        do_load(16'hF0E1, 4'b1000, 4'hF, 4'hF, "bndD");
        set_exp(16'hF0E1, 4'b1000, 4'hF, 4'hF);
        run_until(192, "showD");

        // 5: brightness 3 on digit 0 only
        do_load(16'h0009, 4'b0000, 4'b0001, 4'd3, "loadP");
        run_until(224, "showD");
        set_exp(16'h0009, 4'b0000, 4'b0001, 4'd3);
        run_until(256, "pwm");

        // 6: reset mid-dwell while a load is pending
        do_load(16'hFFFF, 4'hF, 4'hF, 4'hF, "pendE");
        run_until(259, "pwm");
        rst_n = 1'b0;
        #1;
        check_blank_reset("rst_async");
        @(negedge CLK100_IN);
        check_blank_reset("rst_hold");
        @(negedge CLK100_IN);
        set_exp(16'h0000, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        cyc   = 0;
        run_until(70, "postrst");
        do_load(16'h4321, 4'b0000, 4'hF, 4'hF, "loadF");
        run_until(96, "postrst");
        set_exp(16'h4321, 4'b0000, 4'hF, 4'hF);
        run_until(130, "showF");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
